// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: operand layout, sum width and FSM states.
package adder_arbiter_pkg;

    localparam int OP_W    = 33;
    localparam int SUM_W   = 10;
    localparam int FIELD_W = 8;

    // Operand layout {cin, w, z, y, x}
    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 8;
    localparam int Z_LSB   = 16;
    localparam int W_LSB   = 24;
    localparam int CIN_BIT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder.sv
// Shared datapath: sums four 8-bit fields plus carry-in and registers the
// sum together with a zero flag.
module adder
    import adder_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  ins,
    output logic [SUM_W-1:0] sm_r,
    output logic             sm_zero_r
);

    logic [SUM_W-1:0] sm;

    always_comb begin
        sm = SUM_W'(ins[X_LSB +: FIELD_W])
           + SUM_W'(ins[Y_LSB +: FIELD_W])
           + SUM_W'(ins[Z_LSB +: FIELD_W])
           + SUM_W'(ins[W_LSB +: FIELD_W])
           + SUM_W'(ins[CIN_BIT]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_r      <= '0;
            sm_zero_r <= 1'b0;
        end else begin
            sm_r      <= sm;
            sm_zero_r <= (sm == '0);
        end
    end

endmodule

// File: rtl/adder_arbiter_rr_grant.sv
// Round-robin grant: first asserted request strictly after the pointer,
// wrapping modulo NREQ. Purely combinational.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NREQ requesters, with a registered
// response channel carrying sum, zero flag and requester ID.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int CNTW = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_ins,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SUM_W-1:0]     rsp_sum,
    output logic                 rsp_zero,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [CNTW-1:0]      done_cnt
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [SUM_W-1:0] sm_r;
    logic             sm_zero_r;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    adder u_adder (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins       (op_q),
        .sm_r      (sm_r),
        .sm_zero_r (sm_zero_r)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|req_valid) begin
                    op_d    = req_ins[OP_W*gnt_idx +: OP_W];
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    state_d = CALC;
                end
            end
            // Adder registers the sum of op_q on the edge leaving CALC.
            CALC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            id_q    <= '0;
            ptr_q   <= IDW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response fields are only meaningful in RESP; elsewhere they read as zero.
    assign rsp_valid = (state_q == RESP);
    assign rsp_sum   = rsp_valid ? sm_r : '0;
    assign rsp_zero  = rsp_valid & sm_zero_r;
    assign rsp_id    = rsp_valid ? id_q : '0;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*33-1:0]   req_ins;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [9:0]           rsp_sum;
    logic                 rsp_zero;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;
    logic [15:0]          done_cnt;

    logic [NREQ-1:0]      req_ready_c;
    logic                 rsp_valid_c;
    logic [9:0]           rsp_sum_c;
    logic                 rsp_zero_c;
    logic [IDW-1:0]       rsp_id_c;
    logic                 busy_c;
    logic [1:0]           done_cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.NREQ(NREQ), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ins(req_ins), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
        .busy(busy), .done_cnt(done_cnt)
    );

    adder_arbiter #(.NREQ(NREQ), .CNTW(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_c),
        .req_ins(req_ins), .rsp_valid(rsp_valid_c), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum_c), .rsp_zero(rsp_zero_c), .rsp_id(rsp_id_c),
        .busy(busy_c), .done_cnt(done_cnt_c)
    );

    function automatic logic [32:0] mk(input logic cin, input logic [7:0] w, input logic [7:0] z,
                                       input logic [7:0] y, input logic [7:0] x);
        return {cin, w, z, y, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_ins   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0d exp 0", rsp_valid); end
        checks++; if (rsp_sum !== 10'd0) begin errors++; $display("FAIL reset_rsp_sum got %0d exp 0", rsp_sum); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got %0d exp 0", rsp_zero); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt got %0d exp 0", done_cnt); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        $display("reset: done_cnt=%0d busy=%0d", done_cnt, busy);
    endtask

    task automatic test_single();
        req_ins[33*2 +: 33] = mk(1'b1, 8'd4, 8'd3, 8'd2, 8'd1);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc_valid got %0d exp 0", rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_calc_busy got %0d exp 1", busy); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0d exp 1", rsp_valid); end
        checks++; if (rsp_sum !== 10'd11) begin errors++; $display("FAIL single_rsp_sum got %0d exp 11", rsp_sum); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL single_rsp_zero got %0d exp 0", rsp_zero); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
        $display("txn: id=%0d sum=%0d zero=%0d", rsp_id, rsp_sum, rsp_zero);
        tick();
        checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL single_done_cnt got %0d exp 1", done_cnt); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got %0d exp 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        for (int i = 0; i < NREQ; i++) req_ins[33*i +: 33] = mk(1'b0, 8'd3, 8'd2, 8'd1, 8'(i * 10));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            e = k % NREQ;
            checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_req_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << e)); end
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_calc_valid[%0d] got %0d exp 0", k, rsp_valid); end
            tick();
            checks++; if (rsp_id !== 2'(e)) begin errors++; $display("FAIL rr_rsp_id[%0d] got %0d exp %0d", k, rsp_id, e); end
            checks++; if (rsp_sum !== 10'(e * 10 + 6)) begin errors++; $display("FAIL rr_rsp_sum[%0d] got %0d exp %0d", k, rsp_sum, e * 10 + 6); end
            $display("txn: id=%0d sum=%0d zero=%0d", rsp_id, rsp_sum, rsp_zero);
            tick();
        end
        req_valid = '0;
        checks++; if (done_cnt !== 16'd6) begin errors++; $display("FAIL rr_done_cnt got %0d exp 6", done_cnt); end
    endtask

    task automatic test_extremes();
        req_ins[33*1 +: 33] = mk(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ext_req_ready got %b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_sum !== 10'd1021) begin errors++; $display("FAIL ext_max_sum got %0d exp 1021", rsp_sum); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL ext_max_zero got %0d exp 0", rsp_zero); end
        $display("txn: id=%0d sum=%0d zero=%0d", rsp_id, rsp_sum, rsp_zero);
        tick();
        req_ins[33*1 +: 33] = '0;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_sum !== 10'd0) begin errors++; $display("FAIL ext_zero_sum got %0d exp 0", rsp_sum); end
        checks++; if (rsp_zero !== 1'b1) begin errors++; $display("FAIL ext_zero_flag got %0d exp 1", rsp_zero); end
        $display("txn: id=%0d sum=%0d zero=%0d", rsp_id, rsp_sum, rsp_zero);
        tick();
        checks++; if (done_cnt !== 16'd8) begin errors++; $display("FAIL ext_done_cnt got %0d exp 8", done_cnt); end
    endtask

    task automatic test_backpressure();
        req_ins[33*3 +: 33] = mk(1'b0, 8'd0, 8'd0, 8'd0, 8'd5);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_req_ready got %b exp 1000", req_ready); end
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0d exp 1", c, rsp_valid); end
            checks++; if (rsp_sum !== 10'd5) begin errors++; $display("FAIL bp_sum[%0d] got %0d exp 5", c, rsp_sum); end
            checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL bp_id[%0d] got %0d exp 3", c, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready[%0d] got %b exp 0000", c, req_ready); end
            checks++; if (done_cnt !== 16'd8) begin errors++; $display("FAIL bp_done_cnt[%0d] got %0d exp 8", c, done_cnt); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_exit_req_ready got %b exp 0000", req_ready); end
        $display("txn: id=%0d sum=%0d zero=%0d", rsp_id, rsp_sum, rsp_zero);
        tick();
        checks++; if (done_cnt !== 16'd9) begin errors++; $display("FAIL bp_done_after got %0d exp 9", done_cnt); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b exp 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        req_ins[33*2 +: 33] = mk(1'b0, 8'd0, 8'd0, 8'd0, 8'd9);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_calc got %0d exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0d exp 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0d exp 0", rsp_valid); end
        checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL mid_done_cnt got %0d exp 0", done_cnt); end
        checks++; if (rsp_sum !== 10'd0) begin errors++; $display("FAIL mid_sum got %0d exp 0", rsp_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp[%0d] got %0d exp 0", c, rsp_valid); end
        end
        req_ins[0 +: 33] = mk(1'b0, 8'd0, 8'd0, 8'd0, 8'd7);
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL mid_rsp_id got %0d exp 0", rsp_id); end
        checks++; if (rsp_sum !== 10'd7) begin errors++; $display("FAIL mid_rsp_sum got %0d exp 7", rsp_sum); end
        $display("txn: id=%0d sum=%0d zero=%0d", rsp_id, rsp_sum, rsp_zero);
        tick();
        checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL mid_done_cnt_after got %0d exp 1", done_cnt); end
    endtask

    task automatic test_sat_counter();
        int exp_c;
        do_reset();
        req_ins[33*1 +: 33] = mk(1'b0, 8'd0, 8'd0, 8'd1, 8'd2);
        rsp_ready = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            req_valid = 4'b0010;
            #1;
            checks++; if (req_ready_c !== 4'b0010) begin errors++; $display("FAIL sat_req_ready[%0d] got %b exp 0010", n, req_ready_c); end
            tick();
            req_valid = '0;
            checks++; if (busy_c !== 1'b1) begin errors++; $display("FAIL sat_busy[%0d] got %0d exp 1", n, busy_c); end
            tick();
            checks++; if (rsp_valid_c !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d] got %0d exp 1", n, rsp_valid_c); end
            checks++; if (rsp_sum_c !== 10'd3 || rsp_zero_c !== 1'b0 || rsp_id_c !== 2'd1) begin
                errors++; $display("FAIL sat_rsp[%0d] got sum=%0d zero=%0d id=%0d exp sum=3 zero=0 id=1", n, rsp_sum_c, rsp_zero_c, rsp_id_c);
            end
            tick();
            exp_c = (n > 3) ? 3 : n;
            checks++; if (done_cnt_c !== 2'(exp_c)) begin errors++; $display("FAIL sat_done_cnt_c[%0d] got %0d exp %0d", n, done_cnt_c, exp_c); end
            checks++; if (done_cnt !== 16'(n)) begin errors++; $display("FAIL sat_done_cnt[%0d] got %0d exp %0d", n, done_cnt, n); end
            $display("txn: n=%0d done_cnt_c=%0d done_cnt=%0d", n, done_cnt_c, done_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_ins   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_sat_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Shares one instance of the existing `adder` datapath (4x8-bit field sum plus carry-in, registered sum and zero flag) among NREQ requesters. Each requester offers a packed 33-bit operand over a valid/ready handshake. A round-robin arbiter grants one requester and sequences the operand through the adder. The block then returns the registered result, zero flag and requester ID over a response valid/ready handshake. It sits between the issuing engines and the shared adder.

Parameters:
NREQ, 4, number of requesters (2..16)
CNTW, 16, width of the completed-operation counter
IDW, $clog2(NREQ), localparam; requester-ID width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_ins  in  NREQ*33  packed operands; requester i at bits [33*i+32:33*i]; layout {cin, w, z, y, x}
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_sum  out  10  x+y+z+w+cin
rsp_zero  out  1  1 when rsp_sum==0
rsp_id  out  IDW  requester that issued this result
busy  out  1  1 in any state other than IDLE
done_cnt  out  CNTW  count of responses accepted; saturates at all-ones

Behaviour:
- Reset values: FSM=IDLE, rsp_valid=0, rsp_sum=0, rsp_zero=0, rsp_id=0, busy=0, done_cnt=0, rr pointer=NREQ-1, operand register=0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first asserted req_valid searching from pointer+1 upward, wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally; all other req_ready=0; all 0 if no req_valid.
  - On the accept edge: latch req_ins[grant] into the operand register, latch grant into id register, set pointer=grant, go to CALC.
- CALC:
  - Operand register drives adder ins; adder sm is combinational.
  - At the next edge the adder captures sm_r/sm_zero_r; go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum=adder sm_r; rsp_zero=adder sm_zero_r; rsp_id=id register.
  - All outputs held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: go to IDLE and increment done_cnt (saturating).
- req_ready is 0 in CALC and RESP. No new request is accepted in the RESP-exit cycle.
- Latency: rsp_valid rises in the 2nd cycle after the accept edge, i.e. after 2 clock edges.
- Minimum initiation interval: 3 cycles.
- Width: max sum 4*255+1=1021 fits in 10 bits; no overflow possible.
- Requester deasserting req_valid without handshake: legal; no grant is latched; grant is re-evaluated every cycle in IDLE.
- Pointer changes only on an accept, so an idle gap does not reorder priority.
- Reset mid-operation: the in-flight transaction is discarded, no response is produced, all outputs return to reset values.
- req_ins of non-granted requesters is ignored.

Decomposition:
- Shared package:
  - OP_W=33, SUM_W=10
  - field offsets X/Y/Z/W/CIN
  - FSM state enum {IDLE, CALC, RESP}
- Sub-module rr_grant: NREQ request vector + pointer -> one-hot grant + binary index, purely combinational.
- adder_arbiter instantiates rr_grant and the existing adder, and holds the FSM, operand/id registers and counter.

Test Plan:
1. Requester 2 alone, ins={1,8'd4,8'd3,8'd2,8'd1} -> req_ready=4'b0100; rsp_valid 2 edges after accept; rsp_sum=11, rsp_zero=0, rsp_id=2; done_cnt=1.
2. All four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1; one response per 3 cycles.
3. Operand all 0xFF with cin=1 -> rsp_sum=1021, zero=0; then all-zero operand -> rsp_sum=0, rsp_zero=1.
4. rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout, done_cnt unchanged until the accept cycle.
5. rst_n pulsed low during CALC -> all outputs at reset values immediately; no response. The next request from requester 0 is granted first.
6. CNTW=2, 5 completed operations -> done_cnt reads 1,2,3,3,3.
